// File: rtl/fpu_align.sv
`default_nettype none
// ============================================================================
// Module   : fpu_align
// Purpose  : Single-precision add/sub front end. Unpacks the operands, orders
//            them by magnitude, aligns the smaller mantissa with a multi-cycle
//            shifter and adds/subtracts to an unnormalized 34-bit result.
//            Optional macro FPU_ALIGN_STICKY_EN keeps a sticky bit of the
//            shifted-out mantissa bits and ORs it into result bit [0].
// Revision : 1.0 - initial release
// ============================================================================
module fpu_align #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [33:0] add_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ALIGN = 2'd1;
    localparam logic [1:0] S_ADD   = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [4:0] D_MAX = 5'd25;
    localparam logic [4:0] STEP  = 5'(SHIFT_STEP);

    logic [1:0]  state;
    logic [1:0]  state_nxt;

    logic        sign_big;
    logic [7:0]  exp_big;
    logic [23:0] mant_big;
    logic        sign_small;
    logic [23:0] mant_small;
    logic [4:0]  remaining;
    logic [33:0] add_q;

    // Operand unpack and magnitude ordering
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic        sign_b_eff;
    logic        a_wins;
    logic [7:0]  exp_diff;
    logic [4:0]  d_sat;

    always_comb begin
        exp_a      = (a_i[30:23] != 8'd0) ? a_i[30:23] : 8'd1;
        exp_b      = (b_i[30:23] != 8'd0) ? b_i[30:23] : 8'd1;
        man_a      = {(a_i[30:23] != 8'd0), a_i[22:0]};
        man_b      = {(b_i[30:23] != 8'd0), b_i[22:0]};
        sign_b_eff = b_i[31] ^ sub_i;
        a_wins     = ({exp_a, man_a} >= {exp_b, man_b});
        exp_diff   = a_wins ? (exp_a - exp_b) : (exp_b - exp_a);
        d_sat      = (exp_diff > 8'd25) ? D_MAX : exp_diff[4:0];
    end

    // One alignment step: shift by the smaller of the step size and what is left
    logic [4:0]  step;
    logic [23:0] shifted;
    logic [23:0] lost_mask;
    logic        lost;
    logic [4:0]  remaining_nxt;

    always_comb begin
        step          = (remaining < STEP) ? remaining : STEP;
        shifted       = mant_small >> step;
        lost_mask     = ~(24'hFFFFFF << step);
        lost          = |(mant_small & lost_mask);
        remaining_nxt = remaining - step;
    end

    // Mantissa add/subtract; big >= small so the difference never wraps
    logic        eff_sub;
    logic [24:0] mag_sum;
    logic [24:0] mag_diff;
    logic [24:0] raw;
    logic [24:0] result;

`ifdef FPU_ALIGN_STICKY_EN
    logic sticky;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky <= 1'b0;
        end else if (state == S_IDLE && valid_i) begin
            sticky <= 1'b0;
        end else if (state == S_ALIGN) begin
            sticky <= sticky | lost;
        end
    end

    always_comb begin
        eff_sub  = sign_big ^ sign_small;
        mag_sum  = {1'b0, mant_big} + {1'b0, mant_small};
        mag_diff = {1'b0, mant_big} - {1'b0, mant_small};
        raw      = eff_sub ? mag_diff : mag_sum;
        result   = {raw[24:1], raw[0] | sticky};
    end
`else
    always_comb begin
        eff_sub  = sign_big ^ sign_small;
        mag_sum  = {1'b0, mant_big} + {1'b0, mant_small};
        mag_diff = {1'b0, mant_big} - {1'b0, mant_small};
        raw      = eff_sub ? mag_diff : mag_sum;
        result   = raw;
    end

    logic unused_lost;
    assign unused_lost = lost;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (valid_i) begin
                    state_nxt = (d_sat != 5'd0) ? S_ALIGN : S_ADD;
                end
            end
            S_ALIGN: begin
                if (remaining_nxt == 5'd0) begin
                    state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                state_nxt = S_OUT;
            end
            S_OUT: begin
                if (ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ready_o = (state == S_IDLE);
        valid_o = (state == S_OUT);
        add_o   = add_q;
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sign_big   <= 1'b0;
            exp_big    <= 8'd0;
            mant_big   <= 24'd0;
            sign_small <= 1'b0;
            mant_small <= 24'd0;
            remaining  <= 5'd0;
            add_q      <= 34'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        sign_big   <= a_wins ? a_i[31] : sign_b_eff;
                        exp_big    <= a_wins ? exp_a : exp_b;
                        mant_big   <= a_wins ? man_a : man_b;
                        sign_small <= a_wins ? sign_b_eff : a_i[31];
                        mant_small <= a_wins ? man_b : man_a;
                        remaining  <= d_sat;
                    end
                end
                S_ALIGN: begin
                    mant_small <= shifted;
                    remaining  <= remaining_nxt;
                end
                S_ADD: begin
                    if (eff_sub && raw == 25'd0) begin
                        add_q <= 34'h0;
                    end else begin
                        add_q <= {sign_big, exp_big, result};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_align
// Purpose  : Directed, table-driven checks of fpu_align plus handshake and
//            reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_align;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] a_i = 32'h0;
    logic [31:0] b_i = 32'h0;
    logic        sub_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [33:0] add_o;

    int checks = 0;
    int errors = 0;

`ifdef FPU_ALIGN_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    fpu_align #(.SHIFT_STEP(1)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .sub_i   (sub_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .add_o   (add_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [33:0] exp_add;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Issue one operation, measure latency (accept edge counts as edge 1),
    // hold ready_i low for 'hold' cycles in OUT, then release.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [33:0] exp_add,
                          input int exp_lat, input int hold, input string name);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(ready_o == 1'b1, {name, " ready_o"}, 64'(ready_o), 64'd1);
        a_i = a; b_i = b; sub_i = sub; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        a_i = 32'hDEADBEEF; b_i = 32'h12345678;
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check(valid_o && lat == exp_lat, {name, " latency"}, 64'(lat), 64'(exp_lat));
        check(add_o == exp_add, {name, " add_o"}, 64'(add_o), 64'(exp_add));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check(valid_o == 1'b1 && add_o == exp_add && ready_o == 1'b0,
                  {name, " hold"}, {29'd0, valid_o, ready_o, add_o}, {29'd0, 1'b1, 1'b0, exp_add});
        end
        // Offer a new operand on the release edge; it must not be taken
        ready_i = 1'b1; valid_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0; valid_i = 1'b0;
        check(ready_o == 1'b1 && valid_o == 1'b0, {name, " release"},
              {62'd0, ready_o, valid_o}, 64'd2);
        @(posedge clk); #1;
        check(ready_o == 1'b1, {name, " no accept on release"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, {1'b0, 8'h7F, 25'h1000000}, 2};
        vecs[1]  = '{32'h3F800000, 32'h3F000000, 1'b0, {1'b0, 8'h7F, 25'h0C00000}, 3};
        vecs[2]  = '{32'h3F000000, 32'h3F800000, 1'b1, {1'b1, 8'h7F, 25'h0400000}, 3};
        vecs[3]  = '{32'h3F800000, 32'h3F800000, 1'b1, 34'h0, 2};
        vecs[4]  = '{32'h4E800000, 32'h3F800000, 1'b0, {1'b0, 8'h9D, 24'h400000, STK}, 27};
        vecs[5]  = '{32'h00000001, 32'h00000002, 1'b0, {1'b0, 8'h01, 25'h0000003}, 2};
        vecs[6]  = '{32'hC0000000, 32'h3F800000, 1'b0, {1'b1, 8'h80, 25'h0400000}, 3};
        vecs[7]  = '{32'h7F800000, 32'h7F800000, 1'b0, {1'b0, 8'hFF, 25'h1000000}, 2};
        vecs[8]  = '{32'hBF800000, 32'h3F800000, 1'b1, {1'b1, 8'h7F, 25'h1000000}, 2};
        vecs[9]  = '{32'h41000000, 32'h3F800000, 1'b0, {1'b0, 8'h82, 25'h0900000}, 5};
        vecs[10] = '{32'h40000000, 32'h3F800001, 1'b0, {1'b0, 8'h80, 24'h600000, STK}, 3};
        vecs[11] = '{32'h00400000, 32'h00800000, 1'b0, {1'b0, 8'h01, 25'h0C00000}, 2};

        // Reset state
        #12;
        check(ready_o == 1'b1 && valid_o == 1'b0 && add_o == 34'h0, "reset state",
              {29'd0, ready_o, valid_o, add_o}, {29'd0, 1'b1, 1'b0, 34'h0});
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_add,
                   vecs[i].lat, 0, $sformatf("vec%0d", i));
        end

        // Back-pressure: ready_i low for 5 cycles in OUT
        run_op(32'h3F800000, 32'h3F000000, 1'b0, {1'b0, 8'h7F, 25'h0C00000}, 3, 5, "backpressure");

        // Reset mid-ALIGN
        @(negedge clk);
        a_i = 32'h4E800000; b_i = 32'h3F800000; sub_i = 1'b0; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) begin
            @(posedge clk);
        end
        #2;
        check(ready_o == 1'b0, "busy before reset", 64'(ready_o), 64'd0);
        rst_n = 1'b0;
        #1;
        check(valid_o == 1'b0 && add_o == 34'h0 && ready_o == 1'b1, "async reset",
              {29'd0, ready_o, valid_o, add_o}, {29'd0, 1'b1, 1'b0, 34'h0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o || !ready_o) stale++;
        end
        check(stale == 0, "no stale result", 64'(stale), 64'd0);

        // Normal operation after reset
        run_op(vecs[0].a, vecs[0].b, vecs[0].sub, vecs[0].exp_add, vecs[0].lat, 0, "post reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_align.md
FPU_ALIGN -- requirements
Module: fpu_align

Interface
REQ-001 SHALL have parameter SHIFT_STEP, default 1, the number of mantissa bits shifted right per ALIGN cycle; legal values are 1, 2, 4, 8.
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port valid_i, input, 1 bit: operands and sub_i are valid.
REQ-005 SHALL have port ready_o, output, 1 bit: the block can accept operands (high only in IDLE).
REQ-006 SHALL have ports a_i and b_i, inputs, 32 bits each: IEEE-754 single-precision operands.
REQ-007 SHALL have port sub_i, input, 1 bit: 1 computes a-b, 0 computes a+b.
REQ-008 SHALL have port valid_o, output, 1 bit: add_o holds a result.
REQ-009 SHALL have port ready_i, input, 1 bit: the downstream normalizer accepts add_o.
REQ-010 SHALL have port add_o, output, 34 bits: [33] sign, [32:25] exponent, [24:0] unnormalized mantissa ([24] carry, [23] hidden-bit position).

Function
REQ-011 SHALL accept operands on a rising edge where valid_i and ready_o are both high; inputs are sampled only at this accept edge.
REQ-012 SHALL unpack each operand to a hidden bit, an effective exponent and a 24-bit mantissa: hidden=1 and exponent=field when exp field!=0; hidden=0 and exponent=1 when exp field==0.
REQ-013 SHALL treat b's sign as b[31] XOR sub_i.
REQ-014 SHALL perform exponent field 255 as an ordinary value, with no NaN/Inf handling.
REQ-015 SHALL select as "big" the operand with the larger magnitude {exponent, mantissa} and the other as "small", with a winning ties.
REQ-016 SHALL set d = exp_big - exp_small, saturated to 25.
REQ-017 SHALL implement FSM states IDLE, ALIGN, ADD, OUT; the accept edge goes to ALIGN if d>0, otherwise to ADD.
REQ-018 SHALL, in each ALIGN cycle, shift the small mantissa right by min(SHIFT_STEP, remaining) bits and decrement remaining; the state goes to ADD when remaining reaches 0.
REQ-019 SHALL spend exactly ceil(d/SHIFT_STEP) cycles in ALIGN.
REQ-020 SHALL, in ADD (one cycle), add the mantissas when the effective signs are equal and otherwise subtract (big - small, never negative).
REQ-021 SHALL register add_o in ADD as {sign_big, exp_big, 25-bit result}, then go to OUT.
REQ-022 SHALL, when the subtraction result is exactly 0, register add_o = 34'h0.
REQ-023 SHALL assert valid_o only in OUT, from the (ceil(d/SHIFT_STEP)+2)th rising edge after the accept edge.
REQ-024 SHALL hold add_o and valid_o stable in OUT while ready_i is low.
REQ-025 SHALL go from OUT to IDLE on the edge where valid_o and ready_i are both high; no new operand is accepted on that edge.

Reset
REQ-026 SHALL, while rst_ni is low and independent of clk_i, force state=IDLE, valid_o=0, add_o=34'h0, ready_o=1, and clear all internal registers.
REQ-027 SHALL abandon any in-flight operation on reset, with no output produced after reset release.

Configuration
REQ-028 SHALL, with macro FPU_ALIGN_STICKY_EN defined, OR every bit shifted out of the small mantissa into a sticky bit, and OR that bit into result bit [0] in ADD.
REQ-029 SHALL, without FPU_ALIGN_STICKY_EN, discard shifted-out bits so that the result is truncated.

Verification
REQ-030 SHALL cover: a=0x3F800000, b=0x3F800000, sub=0 -> valid_o after 2 edges, add_o={0,8'h7F,25'h1000000}.
REQ-031 SHALL cover: a=0x3F800000, b=0x3F000000, sub=0, SHIFT_STEP=1 -> valid_o after 3 edges, add_o={0,8'h7F,25'h0C00000}.
REQ-032 SHALL cover: a=0x3F000000, b=0x3F800000, sub=1 -> operands swap, add_o={1,8'h7F,25'h0400000}; and a=b=0x3F800000, sub=1 -> add_o=34'h0.
REQ-033 SHALL cover: a=0x4E800000, b=0x3F800000, sub=0 (d saturates to 25), SHIFT_STEP=1 -> valid_o after 27 edges, add_o mantissa 25'h0800000 without the macro and 25'h0800001 with it.
REQ-034 SHALL cover: ready_i held low 5 cycles in OUT -> add_o and valid_o stable throughout and ready_o low; ready_i high -> IDLE next edge and ready_o=1.
REQ-035 SHALL cover: rst_ni pulsed low mid-ALIGN -> valid_o=0, add_o=0, ready_o=1 immediately, and no stale result after release.
